// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the pipelined ALU.
//   arith_op_e : Op encodings when L=0 (negate A, negate B, add, subtract)
//   logic_op_e : Op encodings when L=1 (and, or, xor, not A)
//   flags_t    : registered status flags {Z,C,S,V}
package alu_pipe_pkg;

  typedef enum logic [1:0] {
    OP_NEGA = 2'b00,
    OP_NEGB = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } arith_op_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } logic_op_e;

  typedef struct packed {
    logic z;  // result is zero
    logic c;  // carry out (for subtract: 1 = no borrow)
    logic s;  // sign, result msb
    logic v;  // two's-complement overflow
  } flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_core: purely combinational ALU datapath.
//   a, b   : operands
//   cin    : carry-in for add/subtract (already selected by the caller)
//   l      : 1 = logic op, 0 = arithmetic op
//   op     : operation select (arith_op_e / logic_op_e)
//   r      : result
//   flags  : {Z,C,S,V} derived from this result
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             l,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r,
  output flags_t           flags
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  arith_op_e      aop;
  logic_op_e      lop;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] cin_ext;
  logic           msb_a;
  logic           msb_b;
  logic           msb_r;

  assign aop     = arith_op_e'(op);
  assign lop     = logic_op_e'(op);
  assign cin_ext = {{WIDTH{1'b0}}, cin};
  assign msb_a   = a[WIDTH-1];
  assign msb_b   = b[WIDTH-1];

  always_comb begin
    sum     = '0;
    r       = '0;
    flags   = '0;
    msb_r   = 1'b0;
    if (!l) begin
      // One extra bit on every arithmetic sum so the carry falls out as bit WIDTH.
      case (aop)
        OP_NEGA: sum = {1'b0, ~a} + ONE;
        OP_NEGB: sum = {1'b0, ~b} + ONE;
        OP_ADD:  sum = {1'b0, a} + {1'b0, b} + cin_ext;
        OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + cin_ext;
        default: sum = '0;
      endcase
      r       = sum[WIDTH-1:0];
      msb_r   = sum[WIDTH-1];
      flags.c = sum[WIDTH];
      case (aop)
        // Negation only overflows on the most negative value, the one
        // input whose negation keeps the sign bit set.
        OP_NEGA: flags.v = msb_a & msb_r;
        OP_NEGB: flags.v = msb_b & msb_r;
        OP_ADD:  flags.v = (msb_a == msb_b) && (msb_r != msb_a);
        OP_SUB:  flags.v = (msb_a != msb_b) && (msb_r != msb_a);
        default: flags.v = 1'b0;
      endcase
    end else begin
      case (lop)
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_NOT:  r = ~a;
        default: r = '0;
      endcase
    end
    flags.z = (r == '0);
    flags.s = r[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand beat handshake
//   A, B, L, Op           : operands and operation select
//   use_acc               : take operand A from the accumulator
//   use_cin               : add/subtract take the registered C flag as carry-in
//   out_valid / out_ready : result handshake
//   R, Z, C, S, V         : registered result and flags
//   acc                   : accumulator (always equals the last computed R)
// Stage 1 captures the beat; stage 2 computes and registers result, flags and acc.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             L,
  input  logic [1:0]       Op,
  input  logic             use_acc,
  input  logic             use_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             C,
  output logic             S,
  output logic             V,
  output logic [WIDTH-1:0] acc
);

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             l_p1;
  logic [1:0]       op_p1;
  logic             use_acc_p1;
  logic             use_cin_p1;

  logic [WIDTH-1:0] r_p2;
  flags_t           flags_p2;
  logic [WIDTH-1:0] acc_p2;

  logic             accept;
  logic             s2_load;
  logic [WIDTH-1:0] opa;
  logic             core_cin;
  logic [WIDTH-1:0] core_r;
  flags_t           core_flags;

  // Stage 2 may load whenever its current contents are gone or leaving now,
  // so a full pipeline with a consuming sink still accepts one beat per cycle.
  assign s2_load  = vld_p1 && (!out_valid || out_ready);
  assign in_ready = !vld_p1 || s2_load;
  assign accept   = in_valid && in_ready;

  // ---- stage 1: capture the accepted beat ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1       <= A;
      b_p1       <= B;
      l_p1       <= L;
      op_p1      <= Op;
      use_acc_p1 <= use_acc;
      use_cin_p1 <= use_cin;
    end
  end

  // Accumulator and C are read at s2_load, when they already hold the
  // preceding beat's result, so back-to-back chaining needs no forwarding.
  // Without use_cin, subtract defaults to carry-in 1 (no borrow), add to 0.
  assign opa      = use_acc_p1 ? acc_p2 : a_p1;
  assign core_cin = use_cin_p1 ? flags_p2.c : (op_p1 == OP_SUB);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (opa),
    .b     (b_p1),
    .cin   (core_cin),
    .l     (l_p1),
    .op    (op_p1),
    .r     (core_r),
    .flags (core_flags)
  );

  // ---- stage 2: compute and register result, flags, accumulator ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      r_p2      <= '0;
      flags_p2  <= '0;
      acc_p2    <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      r_p2      <= core_r;
      flags_p2  <= core_flags;
      acc_p2    <= core_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign R   = r_p2;
  assign Z   = flags_p2.z;
  assign C   = flags_p2.c;
  assign S   = flags_p2.s;
  assign V   = flags_p2.v;
  assign acc = acc_p2;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vector table,
// hand-written multi-cycle sequences, and randomized traffic scored against
// an arithmetic reference model.
module tb_alu_pipe;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       l;
  logic [1:0] op;
  logic       use_acc;
  logic       use_cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r;
  logic       z;
  logic       c;
  logic       s;
  logic       v;
  logic [7:0] acc;

  int errors = 0;
  int checks = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .L         (l),
    .Op        (op),
    .use_acc   (use_acc),
    .use_cin   (use_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (r),
    .Z         (z),
    .C         (c),
    .S         (s),
    .V         (v),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;   // {z,c,s,v}
  } exp_t;

  typedef struct {
    logic       l;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;   // {z,c,s,v}
  } vec_t;

  exp_t exp_q[$];
  bit   sb_on = 0;
  int   m_acc = 0;
  int   m_c   = 0;
  bit   last_accept;
  bit   last_fire;
  logic [7:0] last_r;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: flags zcsv got %b required %b", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference: each accepted beat is evaluated in order against the running
  // accumulator/carry, using plain integer arithmetic.
  task automatic model_push();
    int ra, rb, ci, t, st, rr;
    int cc, vv;
    exp_t e;
    ra = use_acc ? m_acc : int'(a);
    rb = int'(b);
    cc = 0;
    vv = 0;
    rr = 0;
    if (l) begin
      case (op)
        2'd0: rr = ra & rb;
        2'd1: rr = ra | rb;
        2'd2: rr = ra ^ rb;
        default: rr = 255 - ra;
      endcase
    end else begin
      case (op)
        2'd0: begin rr = (256 - ra) % 256; cc = (ra == 0); vv = (ra == 128); end
        2'd1: begin rr = (256 - rb) % 256; cc = (rb == 0); vv = (rb == 128); end
        2'd2: begin
          ci = use_cin ? m_c : 0;
          t  = ra + rb + ci;
          rr = t % 256;
          cc = (t > 255);
          st = sgn(ra) + sgn(rb) + ci;
          vv = (st > 127 || st < -128);
        end
        default: begin
          ci = use_cin ? m_c : 1;
          t  = ra + (255 - rb) + ci;
          rr = t % 256;
          cc = (t > 255);
          st = sgn(ra) - sgn(rb) - (1 - ci);
          vv = (st > 127 || st < -128);
        end
      endcase
    end
    e.r = 8'(rr);
    e.f = {rr == 0, cc != 0, rr > 127, vv != 0};
    m_acc = rr;
    m_c   = cc;
    exp_q.push_back(e);
  endtask

  // One clock: handshakes are observed at the falling edge, then the bench
  // resumes 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    last_accept = in_valid && in_ready;
    last_fire   = out_valid && out_ready;
    last_r      = r;
    if (sb_on) begin
      if (last_fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: output R=%h with no beat outstanding", r);
        end else begin
          e = exp_q.pop_front();
          chk8("sb_r", r, e.r);
          chk4("sb_flags", {z, c, s, v}, e.f);
          chk8("sb_acc", acc, e.r);
        end
      end
      if (last_accept) model_push();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic tl, input logic [1:0] top, input logic [7:0] ta,
                       input logic [7:0] tb_, input logic tua, input logic tuc);
    l = tl; op = top; a = ta; b = tb_; use_acc = tua; use_cin = tuc;
    in_valid = 1'b1;
  endtask

  vec_t tbl[14];
  logic [7:0] got[$];
  int nacc;

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 4'b1100};
    tbl[1]  = '{1'b0, 2'd0, 8'h80, 8'h00, 8'h80, 4'b0011};
    tbl[2]  = '{1'b0, 2'd0, 8'h01, 8'h00, 8'hFF, 4'b0010};
    tbl[3]  = '{1'b0, 2'd1, 8'h33, 8'h80, 8'h80, 4'b0011};
    tbl[4]  = '{1'b0, 2'd1, 8'h55, 8'h00, 8'h00, 4'b1100};
    tbl[5]  = '{1'b0, 2'd2, 8'hFF, 8'h01, 8'h00, 4'b1100};
    tbl[6]  = '{1'b0, 2'd2, 8'h7F, 8'h01, 8'h80, 4'b0011};
    tbl[7]  = '{1'b0, 2'd3, 8'h05, 8'h07, 8'hFE, 4'b0010};
    tbl[8]  = '{1'b0, 2'd3, 8'h80, 8'h01, 8'h7F, 4'b0101};
    tbl[9]  = '{1'b1, 2'd0, 8'hC3, 8'h5A, 8'h42, 4'b0000};
    tbl[10] = '{1'b1, 2'd1, 8'hC3, 8'h5A, 8'hDB, 4'b0010};
    tbl[11] = '{1'b1, 2'd2, 8'hC3, 8'h5A, 8'h99, 4'b0010};
    tbl[12] = '{1'b1, 2'd3, 8'hC3, 8'h5A, 8'h3C, 4'b0000};
    tbl[13] = '{1'b1, 2'd0, 8'hF0, 8'h0F, 8'h00, 4'b1000};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; l = 1'b0; op = '0; use_acc = 1'b0; use_cin = 1'b0;
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_r", r, 8'h00);
    chk4("rst_flags", {z, c, s, v}, 4'b0000);
    chk8("rst_acc", acc, 8'h00);
    chk1("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-beat vectors, checking latency on each.
    foreach (tbl[i]) begin
      drive(tbl[i].l, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      chk1($sformatf("vec%0d_lat", i), out_valid, 1'b0);
      step();
      chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk8($sformatf("vec%0d_r", i), r, tbl[i].r);
      chk4($sformatf("vec%0d_flags", i), {z, c, s, v}, tbl[i].f);
    end

    // Carry chain: 00FF + 0001 as two 8-bit words.
    drive(1'b0, 2'd2, 8'hFF, 8'h01, 1'b0, 1'b0);
    step();
    drive(1'b0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk8("chain_lo_r", r, 8'h00);
    chk1("chain_lo_c", c, 1'b1);
    step();
    chk8("chain_hi_r", r, 8'h01);
    chk1("chain_hi_c", c, 1'b0);
    chk1("chain_hi_z", z, 1'b0);

    // Accumulator, back-to-back beats.
    do_reset();
    drive(1'b0, 2'd2, 8'h77, 8'h05, 1'b1, 1'b0);
    step();
    chk1("acc_lat", out_valid, 1'b0);
    step();
    chk1("acc_v1", out_valid, 1'b1);
    chk8("acc_r1", r, 8'h05);
    step();
    in_valid = 1'b0;
    chk8("acc_r2", r, 8'h0A);
    step();
    chk8("acc_r3", r, 8'h0F);
    chk8("acc_final", acc, 8'h0F);
    use_acc = 1'b0;

    // Backpressure: two beats absorbed, then stall, then in-order drain.
    do_reset();
    out_ready = 1'b0;
    drive(1'b0, 2'd2, 8'h01, 8'h00, 1'b0, 1'b0);
    nacc = 0;
    repeat (4) begin
      step();
      if (last_accept) begin nacc++; a = 8'(nacc + 1); end
    end
    chki("bp_accepted", nacc, 2);
    chk1("bp_in_ready", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk8("bp_r_held", r, 8'h01);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_fire) got.push_back(last_r);
      if (last_accept) begin
        nacc++;
        if (nacc >= 3) in_valid = 1'b0;
        else a = 8'(nacc + 1);
      end
    end
    chki("bp_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++)
      chk8($sformatf("bp_order%0d", i), got[i], 8'(i + 1));

    // Reset with both stages full.
    do_reset();
    out_ready = 1'b0;
    drive(1'b0, 2'd2, 8'h7F, 8'h01, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'd0, 8'hC3, 8'h5A, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk1("pre_rst_valid", out_valid, 1'b1);
    chk8("pre_rst_acc", acc, 8'h80);
    chk1("pre_rst_in_ready", in_ready, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk8("mid_rst_acc", acc, 8'h00);
    chk8("mid_rst_r", r, 8'h00);
    chk4("mid_rst_flags", {z, c, s, v}, 4'b0000);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    chk1("post_rst_dropped", out_valid, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    m_acc = 0;
    m_c = 0;
    exp_q.delete();
    sb_on = 1;
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = 8'($urandom_range(0, 255));
      b         = 8'($urandom_range(0, 255));
      l         = 1'($urandom_range(0, 1));
      op        = 2'($urandom_range(0, 3));
      use_acc   = 1'($urandom_range(0, 1));
      use_cin   = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    sb_on = 0;
    chki("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
